// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Shared constants and configuration helpers for fifo_sync_param.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Legal configurations: power-of-two depth >= 2, AF in 1..DEPTH, AE in 0..DEPTH-1.
    function automatic bit cfg_ok(input int depth, input int af, input int ae);
        return (depth >= 2) && ((1 << clog2(depth)) == depth) &&
               (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram
//  Purpose  : DATA_W x DEPTH dual-port RAM; registered read port, or
//             asynchronous read when FIFO_FWFT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_ram
    import fifo_pkg::*;
#(
    parameter  int DATA_W = DEFAULT_DATA_W,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];

    logic unused_ok;
    assign unused_ok = &{1'b0, rst, rd_en};
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Purpose  : Single-clock FIFO with level, almost flags and sticky errors.
//             Define FIFO_FWFT_EN for first-word-fall-through read data.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter  int DATA_W   = DEFAULT_DATA_W,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    parameter  int AE_LEVEL = 2,
    localparam int CNT_W    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_e,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_e,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int PTR_W = clog2(DEPTH);

    if (!cfg_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_cfg
        $fatal(1, "fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] level_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write.
    assign rd_acc = rd_e & ~empty;
    assign wr_acc = wr_e & (~full | rd_acc);

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            level        <= level_nxt;
            empty        <= (level_nxt == '0);
            full         <= (level_nxt == CNT_W'(DEPTH));
            almost_full  <= (level_nxt >= CNT_W'(AF_LEVEL));
            almost_empty <= (level_nxt <= CNT_W'(AE_LEVEL));
            // A new error event takes priority over a coincident clear.
            if (wr_e & ~wr_acc)  overflow  <= 1'b1;
            else if (err_clr)    overflow  <= 1'b0;
            if (rd_e & ~rd_acc)  underflow <= 1'b1;
            else if (err_clr)    underflow <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Purpose  : Queue-model scoreboard bench for fifo_sync_param (DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_e = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_e = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0]    level;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    logic [DW-1:0] m_rd  = '0;

    fifo_sync_param #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_e         (wr_e),
        .wr_data      (wr_data),
        .rd_e         (rd_e),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT accepts a read.
    bit pend = 1'b0;
    always @(negedge clk) begin
`ifdef FIFO_FWFT_EN
        if (rd_e && !rst && !empty) begin
            if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("rd_data_fwft", rd_data, exp_q.pop_front());
        end
`else
        if (pend) begin
            if (exp_q.size() == 0) chk("unexpected_read", 1, 0);
            else chk("rd_data", rd_data, exp_q.pop_front());
        end
        pend = rd_e && !rst && !empty;
`endif
    end

    task automatic cycle(input bit r, input bit we, input logic [DW-1:0] wd,
                         input bit re, input bit clr);
        bit ra, wa;
        rst = r; wr_e = we; wr_data = wd; rd_e = re; err_clr = clr;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd  = '0;
        end else begin
            ra = re && (q.size() > 0);
            wa = we && ((q.size() < DEPTH) || ra);
            if (ra) begin
                m_rd = q.pop_front();
                exp_q.push_back(m_rd);
            end
            if (wa) q.push_back(wd);
            m_ovf = (we && !wa) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (re && !ra) ? 1'b1 : (clr ? 1'b0 : m_unf);
        end
        @(posedge clk);
        #1;
        chk("level", level, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("almost_full", almost_full, q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
`ifdef FIFO_FWFT_EN
        if (q.size() > 0) chk("rd_head", rd_data, q[0]);
`else
        chk("rd_data_hold", rd_data, m_rd);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] fill[4];
        fill = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        @(posedge clk);
        #1;
        // Reset then idle
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        // Fill, overflow, drain, underflow, clear
        foreach (fill[i]) cycle(0, 1, fill[i], 0, 0);
        cycle(0, 1, 8'hEE, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        // Simultaneous read+write while full
        for (int i = 1; i <= 4; i++) cycle(0, 1, DW'(8'h11 * i), 0, 0);
        cycle(0, 1, 8'h55, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        // Pointer wrap with write/read pairs
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, DW'(8'h60 + i), 0, 0);
            cycle(0, 0, 0, 1, 0);
        end
        // Error set wins over coincident clear
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1);
        // Mid-operation reset at level 3
        for (int i = 0; i < 3; i++) cycle(0, 1, DW'(8'h30 + i), 0, 0);
        cycle(1, 1, 8'h99, 1, 0);
        cycle(0, 1, 8'h5A, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        // Randomized traffic: fill-biased then drain-biased phases
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 30;
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < wp,
                  DW'($urandom),
                  $urandom_range(0, 99) < (100 - wp),
                  $urandom_range(0, 99) < 5);
        end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
